zap_wb_mem_responder: RTL and testbench



---
 rtl/zap_wb_mem_responder.sv | 140 ++++++++++++++
 tb/tb_zap_wb_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_mem_responder.sv
// Wishbone B3 slave memory with byte enables, programmable wait states, CTI bursts
// and an error response for unmapped addresses. Outputs are zero when idle so they can be ORed.
module zap_wb_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 1,
    parameter int          BURST_WAIT  = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam int MAX_WAIT = (WAIT_STATES > BURST_WAIT) ? WAIT_STATES : BURST_WAIT;
    localparam int CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] FIRST_CNT = CW'(WAIT_STATES);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_WAIT);
    localparam logic [29:0]   BASE_WORD = BASE_ADDR[31:2];
    localparam logic [29:0]   DEPTH_W30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [29:0]   adr_r;
    logic          wen_r;
    logic [3:0]    sel_r;
    logic [31:0]   dat_r;
    logic [2:0]    cti_r;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [29:0]   word_off_s;
    logic          hit_s;
    logic [AW-1:0] idx_s;
    logic          respond_s;
    logic          accept_s;
    logic          mem_we_s;
    logic          unused_s;

    assign unused_s = &{1'b0, i_wb_adr[1:0]};

    // Address decode of the latched beat and the accept/respond/write strobes.
    always_comb begin
        word_off_s = adr_r - BASE_WORD;
        hit_s      = (word_off_s < DEPTH_W30);
        idx_s      = word_off_s[AW-1:0];
        respond_s  = (state_r == ST_WAIT) && i_wb_cyc && (cnt_r == {CW{1'b0}});
        // A beat still on the bus while its response is out must not be taken twice.
        accept_s   = ((state_r == ST_IDLE) || (state_r == ST_BURST)) && i_wb_cyc && i_wb_stb
                     && !o_wb_ack && !o_wb_err;
        mem_we_s   = respond_s && hit_s && wen_r;
    end

    // Byte-masked storage update on the edge that raises ack; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s && sel_r[0]) begin
            mem[idx_s][7:0] <= dat_r[7:0];
        end
        if (mem_we_s && sel_r[1]) begin
            mem[idx_s][15:8] <= dat_r[15:8];
        end
        if (mem_we_s && sel_r[2]) begin
            mem[idx_s][23:16] <= dat_r[23:16];
        end
        if (mem_we_s && sel_r[3]) begin
            mem[idx_s][31:24] <= dat_r[31:24];
        end
    end

    // Beat sequencing FSM with registered ack/err/data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            adr_r    <= 30'h0;
            wen_r    <= 1'b0;
            sel_r    <= 4'h0;
            dat_r    <= 32'h0;
            cti_r    <= 3'b000;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'h0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'h0;
            case (state_r)
                ST_IDLE, ST_BURST: begin
                    if (!i_wb_cyc) begin
                        state_r <= ST_IDLE;
                    end else if (accept_s) begin
                        adr_r   <= i_wb_adr[31:2];
                        wen_r   <= i_wb_wen;
                        sel_r   <= i_wb_sel;
                        dat_r   <= i_wb_dat;
                        cti_r   <= i_wb_cti;
                        cnt_r   <= (state_r == ST_BURST) ? BURST_CNT : FIRST_CNT;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_WAIT: begin
                    if (!i_wb_cyc) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == {CW{1'b0}}) begin
                        o_wb_ack <= hit_s;
                        o_wb_err <= !hit_s;
                        if (hit_s && !wen_r) begin
                            o_wb_dat <= mem[idx_s];
                        end else begin
                            o_wb_dat <= 32'h0;
                        end
                        state_r <= (hit_s && (cti_r == 3'b010)) ? ST_BURST : ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// Directed scoreboard bench for zap_wb_mem_responder: expectations are queued when a
// beat is driven and popped when the responder answers.
module tb_zap_wb_mem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WS    = 2;
    localparam int          BW    = 0;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic [2:0]  cti = 3'b000;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    typedef struct {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          total = 0;
    int          bad   = 0;

    zap_wb_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS),
        .BURST_WAIT (BW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_wb_cyc(cyc),
        .i_wb_stb(stb),
        .i_wb_wen(wen),
        .i_wb_sel(sel),
        .i_wb_adr(adr),
        .i_wb_dat(wdat),
        .i_wb_cti(cti),
        .o_wb_dat(rdat),
        .o_wb_ack(ack),
        .o_wb_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Master beat: called at posedge+1, returns at posedge+1 of the cycle after the response.
    task automatic do_beat(input string tag, input logic [31:0] a, input logic w,
                           input logic [3:0] s, input logic [31:0] d,
                           input logic [2:0] c, input int waits);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] off;
        logic [31:0] old;
        bit          got;
        off       = a - BASE;
        e.is_err  = !(off < SPAN);
        e.chk_dat = !w || e.is_err;
        e.lat     = 1 + waits;
        e.dat     = 32'h0;
        if (!e.is_err) begin
            old = model[off[7:2]];
            if (!w) begin
                e.dat = old;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) old[8*b +: 8] = d[8*b +: 8];
                end
                model[off[7:2]] = old;
            end
        end
        sb.push_back(e);
        cyc = 1'b1; stb = 1'b1; adr = a; wen = w; sel = s; wdat = d; cti = c;
        @(posedge clk);
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                got_e = sb.pop_front();
                check({tag, ".ack"}, {31'h0, ack}, {31'h0, !got_e.is_err});
                check({tag, ".err"}, {31'h0, err}, {31'h0, got_e.is_err});
                check({tag, ".lat"}, 32'(k), 32'(got_e.lat));
                if (got_e.chk_dat) check({tag, ".dat"}, rdat, got_e.dat);
                got = 1'b1;
            end else begin
                check({tag, ".idle_dat"}, rdat, 32'h0);
            end
        end
        if (!got) begin
            check({tag, ".timeout"}, 32'h0, 32'h1);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        check({tag, ".one_cycle"}, {30'h0, ack, err}, 32'h0);
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle", {30'h0, ack, err}, 32'h0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.ack", {31'h0, ack}, 32'h0);
        check("rst.err", {31'h0, err}, 32'h0);
        check("rst.dat", rdat, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_beat("wr10", BASE + 32'h10, 1'b1, 4'hF, 32'hCAFE_F00D, 3'b000, WS);
        idle(1);

        // Reset during WAIT of a write to 0x10: no response, no write
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h10; wen = 1'b1; sel = 4'hF;
        wdat = 32'h0BAD_BAD0; cti = 3'b000;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rstmid.out", {rdat[29:0], ack, err}, 32'h0);
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        idle(4);
        do_beat("rd10", BASE + 32'h10, 1'b0, 4'hF, 32'h0, 3'b000, WS);
        idle(1);

        // Classic write/read
        do_beat("wr20", BASE + 32'h20, 1'b1, 4'hF, 32'hDEAD_BEEF, 3'b000, WS);
        idle(1);
        do_beat("rd20", BASE + 32'h20, 1'b0, 4'hF, 32'h0, 3'b000, WS);
        idle(1);

        // Byte enables, then reserved CTI read behaves as classic
        do_beat("wrbe", BASE + 32'h20, 1'b1, 4'b0101, 32'h1122_3344, 3'b000, WS);
        do_beat("rdbe", BASE + 32'h20, 1'b0, 4'hF, 32'h0, 3'b011, WS);
        check("be.val", model[8], 32'hDE22_BE44);
        do_beat("rdres", BASE + 32'h10, 1'b0, 4'hF, 32'h0, 3'b000, WS);

        // cyc high with stb low: nothing happens
        cyc = 1'b1; stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("nostb", {30'h0, ack, err}, 32'h0);
        end
        idle(1);

        // Incrementing bursts
        do_beat("bw0", BASE + 32'h40, 1'b1, 4'hF, 32'hA000_0040, 3'b010, WS);
        do_beat("bw1", BASE + 32'h44, 1'b1, 4'hF, 32'hA000_0044, 3'b010, BW);
        do_beat("bw2", BASE + 32'h48, 1'b1, 4'hF, 32'hA000_0048, 3'b010, BW);
        do_beat("bw3", BASE + 32'h4C, 1'b1, 4'hF, 32'hA000_004C, 3'b111, BW);
        idle(1);
        do_beat("br0", BASE + 32'h40, 1'b0, 4'hF, 32'h0, 3'b010, WS);
        do_beat("br1", BASE + 32'h44, 1'b0, 4'hF, 32'h0, 3'b010, BW);
        do_beat("br2", BASE + 32'h48, 1'b0, 4'hF, 32'h0, 3'b010, BW);
        do_beat("br3", BASE + 32'h4C, 1'b0, 4'hF, 32'h0, 3'b111, BW);
        // Back in IDLE: the next beat sees the first-beat wait
        do_beat("postb", BASE + 32'h44, 1'b0, 4'hF, 32'h0, 3'b000, WS);
        idle(1);

        // Error responses
        do_beat("miss", BASE + SPAN, 1'b0, 4'hF, 32'h0, 3'b000, WS);
        idle(1);
        do_beat("bm0", BASE + 32'hF8, 1'b1, 4'hF, 32'h5555_00F8, 3'b010, WS);
        do_beat("bm1", BASE + 32'hFC, 1'b0, 4'hF, 32'h0, 3'b010, BW);
        do_beat("bm2", BASE + SPAN, 1'b1, 4'hF, 32'hFFFF_FFFF, 3'b010, BW);
        do_beat("bm3", BASE + 32'hF8, 1'b0, 4'hF, 32'h0, 3'b010, WS);
        idle(2);

        // Abort a write to 0x30
        do_beat("wr30", BASE + 32'h30, 1'b1, 4'hF, 32'h3030_3030, 3'b000, WS);
        idle(1);
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h30; wen = 1'b1; sel = 4'hF;
        wdat = 32'hFFFF_FFFF; cti = 3'b000;
        @(posedge clk); #1;
        idle(5);
        do_beat("rd30", BASE + 32'h30, 1'b0, 4'hF, 32'h0, 3'b000, WS);
        idle(1);

        check("sb.empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
